// File: rtl/ctrl_unit.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit core.
// Optional CTRL_MEM_WAIT_EN adds a mem_ready handshake for slow memory.
module ctrl_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef CTRL_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    input  logic [7:0] mem_rdata,
    input  logic [7:0] rb_data,
    input  logic       ula_zero,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [3:0] ula_op,
    output logic [1:0] ra_sel,
    output logic [1:0] rb_sel,
    output logic       rb_imm_sel,
    output logic [7:0] imm,
    output logic       reg_we,
    output logic       reg_wsrc,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    state_t     state;
    logic [7:0] ir;
    logic       z_flag;
    logic       ready;

`ifdef CTRL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    logic is_r, is_brzr, is_ji, is_ld, is_st, is_addi, is_halt;
    logic in_exec, in_mem, mem_op;

    assign is_r    = ~ir[7];
    assign is_brzr = ir[7:4] == 4'b1000;
    assign is_ji   = ir[7:4] == 4'b1001;
    assign is_ld   = ir[7:4] == 4'b1010;
    assign is_st   = ir[7:4] == 4'b1011;
    assign is_addi = ir[7:4] == 4'b1100;
    assign is_halt = ir[7:5] == 3'b111;

    assign in_exec = state == S_EXEC;
    assign in_mem  = state == S_MEM;
    assign mem_op  = is_ld | is_st;

    assign ra_sel     = ir[3:2];
    assign rb_sel     = ir[1:0];
    assign imm        = {{6{ir[1]}}, ir[1:0]};
    assign rb_imm_sel = is_addi;
    assign ula_op     = is_addi ? 4'h4 : (is_r ? ir[7:4] : 4'h0);

`ifdef CTRL_MEM_WAIT_EN
    // Keep the load address on the bus while the memory is stalling.
    assign mem_addr = ((in_exec && mem_op) || in_mem) ? rb_data : pc;
`else
    assign mem_addr = (in_exec && mem_op) ? rb_data : pc;
`endif

    assign mem_we   = in_exec & is_st;
    assign reg_we   = (in_exec & (is_r | is_addi)) | (in_mem & ready);
    assign reg_wsrc = in_mem;
    assign halted   = state == S_HALTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= 8'h00;
            z_flag <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 8'd1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    unique case (1'b1)
                        is_r, is_addi: z_flag <= ula_zero;
                        is_brzr: if (z_flag) pc <= rb_data;
                        is_ji:   pc <= pc + {{4{ir[3]}}, ir[3:0]};
                        is_ld:   state <= S_MEM;
                        is_st:   if (!ready) state <= S_EXEC;
                        is_halt: state <= S_HALTED;
                        default: ;
                    endcase
                end
                S_MEM:    if (ready) state <= S_FETCH;
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed program table, wrap and reset cases,
// plus random programs checked against an instruction-level model.
module tb_ctrl_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem_rdata;
    logic [7:0] rb_data;
    logic       ula_zero;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [3:0] ula_op;
    logic [1:0] ra_sel;
    logic [1:0] rb_sel;
    logic       rb_imm_sel;
    logic [7:0] imm;
    logic       reg_we;
    logic       reg_wsrc;
    logic [7:0] pc;
    logic       halted;

    ctrl_unit dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready(1'b1),
`endif
        .mem_rdata(mem_rdata),
        .rb_data(rb_data),
        .ula_zero(ula_zero),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .ula_op(ula_op),
        .ra_sel(ra_sel),
        .rb_sel(rb_sel),
        .rb_imm_sel(rb_imm_sel),
        .imm(imm),
        .reg_we(reg_we),
        .reg_wsrc(reg_wsrc),
        .pc(pc),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] regs [4];

    always @(posedge clk) mem_rdata <= mem[mem_addr];
    assign rb_data = regs[rb_sel];

    typedef struct {
        logic       zin;
        int         ncyc;
        logic [7:0] pc;
        logic       chkop;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
        logic       immsel;
        int         rwe;
        int         mwe;
        logic [7:0] xaddr;
        logic       halt;
    } vec_t;

    typedef struct {
        logic [7:0] faddr;
        logic [7:0] xaddr;
        logic [7:0] maddr;
        logic [7:0] pc;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
        logic       immsel;
        logic       wsrc;
        logic       halted;
        int         nrwe;
        int         nmwe;
    } obs_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic zin, input int ncyc, input logic [7:0] npc,
        input logic chkop, input logic [3:0] op, input logic [1:0] ra,
        input logic [1:0] rb, input logic [7:0] im, input logic immsel,
        input int rwe, input int mwe, input logic [7:0] xaddr,
        input logic halt);
        vec_t v;
        v.zin = zin; v.ncyc = ncyc; v.pc = npc; v.chkop = chkop;
        v.op = op; v.ra = ra; v.rb = rb; v.imm = im; v.immsel = immsel;
        v.rwe = rwe; v.mwe = mwe; v.xaddr = xaddr; v.halt = halt;
        return v;
    endfunction

    // Instruction-level reference: next pc, z and bus activity per opcode.
    function automatic vec_t model(input logic [7:0] i, input logic [7:0] p,
                                   inout logic z, input logic zin);
        vec_t v;
        int opc = int'(i[7:4]);
        int off = i[3] ? int'(i[3:0]) - 16 : int'(i[3:0]);
        int nxt = (int'(p) + 1) % 256;
        v = mk(zin, 3, 8'(nxt), 1'b0, 4'h0, i[3:2], i[1:0], 8'h00,
               1'b0, 0, 0, 8'(nxt), 1'b0);
        v.imm = i[1] ? 8'(int'(i[1:0]) - 4 + 256) : 8'(i[1:0]);
        if (opc < 8) begin
            v.rwe = 1; v.chkop = 1; v.op = 4'(opc); z = zin;
        end else if (opc == 8) begin
            if (z) v.pc = regs[i[1:0]];
        end else if (opc == 9) begin
            v.pc = 8'((nxt + off + 256) % 256);
        end else if (opc == 10) begin
            v.ncyc = 4; v.rwe = 1; v.xaddr = regs[i[1:0]];
        end else if (opc == 11) begin
            v.mwe = 1; v.xaddr = regs[i[1:0]];
        end else if (opc == 12) begin
            v.rwe = 1; v.chkop = 1; v.op = 4'h4; v.immsel = 1'b1; z = zin;
        end else if (opc >= 14) begin
            v.halt = 1'b1;
        end
        return v;
    endfunction

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH.
    task automatic exec_instr(input int ncyc, input logic zin,
                              output obs_t o);
        o = '{default: '0};
        ula_zero = zin;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) o.faddr = mem_addr;
            if (c == 2) begin
                o.op = ula_op; o.ra = ra_sel; o.rb = rb_sel;
                o.imm = imm; o.immsel = rb_imm_sel; o.xaddr = mem_addr;
            end
            if (c == 3) o.wsrc = reg_wsrc;
            o.nrwe += int'(reg_we);
            o.nmwe += int'(mem_we);
            if (mem_we) o.maddr = mem_addr;
            @(negedge clk);
        end
        o.pc = pc;
        o.halted = halted;
    endtask

    task automatic compare(input vec_t v, input obs_t o,
                           input logic [7:0] start);
        chk("fetch_addr", o.faddr, start);
        chk("pc", o.pc, v.pc);
        chk("ra_sel", o.ra, v.ra);
        chk("rb_sel", o.rb, v.rb);
        chk("imm", o.imm, v.imm);
        chk("rb_imm_sel", o.immsel, v.immsel);
        chk("exec_mem_addr", o.xaddr, v.xaddr);
        chk("reg_we_count", o.nrwe, v.rwe);
        chk("mem_we_count", o.nmwe, v.mwe);
        chk("halted", o.halted, v.halt);
        if (v.chkop) chk("ula_op", o.op, v.op);
        if (v.mwe != 0) chk("st_addr", o.maddr, v.xaddr);
        if (v.ncyc == 4) chk("ld_wsrc", o.wsrc, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl [12];
    obs_t o;
    vec_t v;
    logic [7:0] cur;
    logic       mz;
    int         strobes;

    initial begin
        rst_n = 1'b0;
        ula_zero = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'hD0;
        mem[8'h00] = 8'h46; mem[8'h01] = 8'h83;
        mem[8'h20] = 8'h00; mem[8'h21] = 8'h83;
        mem[8'h22] = 8'h97; mem[8'h2A] = 8'h9B;
        mem[8'h26] = 8'hA6; mem[8'h27] = 8'hB6;
        mem[8'h28] = 8'hC7; mem[8'h29] = 8'h80;
        mem[8'h11] = 8'hD0; mem[8'h12] = 8'hF0;
        regs[0] = 8'h11; regs[1] = 8'h22;
        regs[2] = 8'h40; regs[3] = 8'h20;

        tbl[0]  = mk(1, 3, 8'h01, 1, 4, 1, 2, 8'hFE, 0, 1, 0, 8'h01, 0);
        tbl[1]  = mk(0, 3, 8'h20, 0, 0, 0, 3, 8'hFF, 0, 0, 0, 8'h02, 0);
        tbl[2]  = mk(0, 3, 8'h21, 1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h21, 0);
        tbl[3]  = mk(0, 3, 8'h22, 0, 0, 0, 3, 8'hFF, 0, 0, 0, 8'h22, 0);
        tbl[4]  = mk(0, 3, 8'h2A, 0, 0, 1, 3, 8'hFF, 0, 0, 0, 8'h23, 0);
        tbl[5]  = mk(0, 3, 8'h26, 0, 0, 2, 3, 8'hFF, 0, 0, 0, 8'h2B, 0);
        tbl[6]  = mk(0, 4, 8'h27, 0, 0, 1, 2, 8'hFE, 0, 1, 0, 8'h40, 0);
        tbl[7]  = mk(0, 3, 8'h28, 0, 0, 1, 2, 8'hFE, 0, 0, 1, 8'h40, 0);
        tbl[8]  = mk(1, 3, 8'h29, 1, 4, 1, 3, 8'hFF, 1, 1, 0, 8'h29, 0);
        tbl[9]  = mk(0, 3, 8'h11, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h2A, 0);
        tbl[10] = mk(0, 3, 8'h12, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h12, 0);
        tbl[11] = mk(0, 3, 8'h13, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h13, 1);

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_reg_we", reg_we, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        rst_n = 1'b1;

        cur = 8'h00;
        for (int k = 0; k < 12; k++) begin
            exec_instr(tbl[k].ncyc, tbl[k].zin, o);
            compare(tbl[k], o, cur);
            cur = tbl[k].pc;
        end

        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            strobes += int'(reg_we) + int'(mem_we);
            if (!halted) strobes += 100;
            @(negedge clk);
        end
        chk("halt_strobes", strobes, 0);
        chk("halt_pc", pc, 8'h13);

        mem[8'h00] = 8'h9E;
        mem[8'hFF] = 8'h97;
        do_reset();
        exec_instr(3, 1'b0, o);
        chk("ji_back_pc", o.pc, 8'hFF);
        exec_instr(3, 1'b0, o);
        chk("ji_wrap_fetch", o.faddr, 8'hFF);
        chk("ji_wrap_pc", o.pc, 8'h07);

        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'($urandom);
            if (mem[a][7:5] == 3'b111) mem[a] = 8'hD0;
        end
        for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
        do_reset();
        cur = 8'h00;
        mz = 1'b0;
        for (int n = 0; n < 300; n++) begin
            v = model(mem[cur], cur, mz, 1'($urandom));
            exec_instr(v.ncyc, v.zin, o);
            compare(v, o, cur);
            cur = v.pc;
        end

        mem[8'h00] = 8'h46;
        do_reset();
        ula_zero = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_abort_reg_we", reg_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_pc", pc, 8'h00);
        chk("abort_reg_we", reg_we, 1'b0);
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_halted", halted, 1'b0);
        chk("abort_mem_addr", mem_addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
